// File: rtl/write_back_arb_pkg.sv
// Shared types for the multi-port writeback arbiter.
// RESULT is the packet carried from the execution units.
package write_back_arb_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_DATA_W-1:0] data;
  } RESULT;

endpackage

// File: rtl/write_back_arb_fifo.sv
// Per-channel result FIFO with synchronous reset.
// Pointers wrap naturally; count is one bit wider.
module result_fifo
  import write_back_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  RESULT                   din,
  output RESULT                   head,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  RESULT mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/write_back_arb.sv
// N-channel to W-port writeback arbiter, round-robin
// with same-destination collision avoidance.
module write_back_arb
  import write_back_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  RESULT                 result [N],
  input  logic [N-1:0]          result_valid,
  output logic [N-1:0]          result_ready,
  output logic [W-1:0]          write_valid,
  output logic [REG_ADDR_W-1:0] write_addr [W],
  output logic [REG_DATA_W-1:0] write_data [W],
  output logic                  idle
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  RESULT                 head [N];
  logic [N-1:0]          empty;
  logic [N-1:0]          full;
  logic [N-1:0]          push;
  logic [N-1:0]          grant;
  logic [CW-1:0]         count [N];
  logic [RW-1:0]         rr;
  logic [RW-1:0]         rr_nxt;
  logic [W-1:0]          wv_nxt;
  logic [REG_ADDR_W-1:0] wa_nxt [W];
  logic [REG_DATA_W-1:0] wd_nxt [W];
  logic                  idle_nxt;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign result_ready[i] = !full[i];
    // dest 0 is accepted but never stored
    assign push[i] = result_valid[i] & result_ready[i]
                   & !reset & (result[i].dest != '0);

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (grant[i]),
      .din   (result[i]),
      .head  (head[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .count (count[i])
    );
  end

  always_comb begin
    int   ng;
    logic hit;
    ng     = 0;
    hit    = 1'b0;
    grant  = '0;
    wv_nxt = '0;
    rr_nxt = rr;
    for (int p = 0; p < W; p++) begin
      wa_nxt[p] = '0;
      wd_nxt[p] = '0;
    end
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (int'(rr) + k == i || int'(rr) + k == i + N) begin
          hit = 1'b0;
          for (int p = 0; p < W; p++)
            if (wv_nxt[p] && wa_nxt[p] == head[i].dest)
              hit = 1'b1;
          if (!empty[i] && ng < W && !hit) begin
            grant[i] = 1'b1;
            for (int p = 0; p < W; p++) begin
              if (p == ng) begin
                wv_nxt[p] = 1'b1;
                wa_nxt[p] = head[i].dest;
                wd_nxt[p] = head[i].data;
              end
            end
            ng     = ng + 1;
            rr_nxt = (i == N - 1) ? '0 : RW'(i + 1);
          end
        end
      end
    end
  end

  always_comb begin
    idle_nxt = ~|wv_nxt;
    for (int i = 0; i < N; i++) begin
      if (push[i] || (count[i] > CW'(1)) ||
          (count[i] == CW'(1) && !grant[i]))
        idle_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr          <= '0;
      write_valid <= '0;
      idle        <= 1'b1;
      for (int p = 0; p < W; p++) begin
        write_addr[p] <= '0;
        write_data[p] <= '0;
      end
    end else begin
      rr          <= rr_nxt;
      write_valid <= wv_nxt;
      idle        <= idle_nxt;
      for (int p = 0; p < W; p++) begin
        write_addr[p] <= wa_nxt[p];
        write_data[p] <= wd_nxt[p];
      end
    end
  end

endmodule

// File: tb/tb_write_back_arb.sv
// Self-checking bench for write_back_arb: directed
// scenarios plus random traffic against a queue model.
module tb_write_back_arb;
  import write_back_arb_pkg::*;

  localparam int N     = 4;
  localparam int W     = 2;
  localparam int DEPTH = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  RESULT                 result [N];
  logic [N-1:0]          result_valid;
  logic [N-1:0]          result_ready;
  logic [W-1:0]          write_valid;
  logic [REG_ADDR_W-1:0] write_addr [W];
  logic [REG_DATA_W-1:0] write_data [W];
  logic                  idle;

  write_back_arb #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .write_valid  (write_valid),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  RESULT                 q [N][$];
  int                    rr_m;
  logic [W-1:0]          exp_valid;
  logic [REG_ADDR_W-1:0] exp_addr [W];
  logic [REG_DATA_W-1:0] exp_data [W];
  logic                  exp_idle;

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after the coming edge, from current inputs
  task automatic model_step();
    int ng;
    int last;
    bit gr [N];
    bit clash;
    logic [REG_ADDR_W-1:0] used [$];
    exp_valid = '0;
    for (int p = 0; p < W; p++) begin
      exp_addr[p] = '0;
      exp_data[p] = '0;
    end
    if (reset) begin
      for (int c = 0; c < N; c++) q[c].delete();
      rr_m     = 0;
      exp_idle = 1'b1;
      return;
    end
    ng   = 0;
    last = 0;
    for (int c = 0; c < N; c++) gr[c] = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rr_m + k) % N;
      if (q[c].size() > 0 && ng < W) begin
        clash = 1'b0;
        foreach (used[u]) if (used[u] == q[c][0].dest) clash = 1'b1;
        if (!clash) begin
          exp_valid[ng] = 1'b1;
          exp_addr[ng]  = q[c][0].dest;
          exp_data[ng]  = q[c][0].data;
          used.push_back(q[c][0].dest);
          gr[c] = 1'b1;
          last  = c;
          ng++;
        end
      end
    end
    if (ng > 0) rr_m = (last + 1) % N;
    for (int c = 0; c < N; c++) begin
      if (result_valid[c] && q[c].size() < DEPTH &&
          result[c].dest != 0)
        q[c].push_back(result[c]);
      if (gr[c]) void'(q[c].pop_front());
    end
    exp_idle = (ng == 0);
    for (int c = 0; c < N; c++)
      if (q[c].size() != 0) exp_idle = 1'b0;
  endtask

  task automatic tick();
    logic [N-1:0] exp_ready;
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++)
      exp_ready[c] = (q[c].size() != DEPTH);
    check("write_valid", write_valid, exp_valid);
    for (int p = 0; p < W; p++) begin
      check($sformatf("write_addr%0d", p), write_addr[p], exp_addr[p]);
      check($sformatf("write_data%0d", p), write_data[p], exp_data[p]);
    end
    check("idle", idle, exp_idle);
    check("result_ready", result_ready, exp_ready);
  endtask

  task automatic clear_in();
    result_valid = '0;
    for (int c = 0; c < N; c++) result[c] = '0;
  endtask

  task automatic set_in(int c, int dest, logic [31:0] data);
    result_valid[c] = 1'b1;
    result[c].dest  = REG_ADDR_W'(dest);
    result[c].data  = data;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    clear_in();
    do_reset();
    check("reset_ready", result_ready, 4'b1111);
    check("reset_idle", idle, 1'b1);
    tick();

    // reset mid-burst
    set_in(0, 7, 32'h70);
    set_in(1, 8, 32'h80);
    set_in(2, 9, 32'h90);
    tick();
    do_reset();
    check("rst_wv", write_valid, 0);
    check("rst_ready", result_ready, 4'b1111);
    check("rst_idle", idle, 1'b1);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("rst_nowrite", write_valid, 0);
    end

    // single packet latency
    set_in(2, 5, 32'hDEADBEEF);
    tick();
    clear_in();
    tick();
    check("lat_wv", write_valid, 2'b01);
    check("lat_addr", write_addr[0], 5);
    check("lat_data", write_data[0], 32'hDEADBEEF);
    tick();
    check("lat_once", write_valid, 0);

    // four channels at once from rr = 0
    do_reset();
    for (int c = 0; c < N; c++) set_in(c, c + 1, 32'h100 + c);
    tick();
    clear_in();
    tick();
    check("all4_wv0", write_valid, 2'b11);
    check("all4_a0", write_addr[0], 1);
    check("all4_a1", write_addr[1], 2);
    tick();
    check("all4_wv1", write_valid, 2'b11);
    check("all4_a2", write_addr[0], 3);
    check("all4_a3", write_addr[1], 4);
    check("all4_rr", dut.rr, 0);

    // same-destination collision
    do_reset();
    set_in(0, 9, 32'hA0);
    set_in(1, 9, 32'hA1);
    set_in(2, 10, 32'hA2);
    tick();
    clear_in();
    tick();
    check("col_wv0", write_valid, 2'b11);
    check("col_a0", write_addr[0], 9);
    check("col_d0", write_data[0], 32'hA0);
    check("col_a1", write_addr[1], 10);
    tick();
    check("col_wv1", write_valid, 2'b01);
    check("col_a2", write_addr[0], 9);
    check("col_d2", write_data[0], 32'hA1);

    // back-pressure on ch3
    do_reset();
    for (int j = 0; j < 12; j++) begin
      for (int c = 0; c < N; c++)
        set_in(c, c * 20 + j + 1, $urandom);
      tick();
      if (j == 1) check("bp_low", result_ready[3], 1'b0);
      if (j == 2) check("bp_high", result_ready[3], 1'b1);
    end
    clear_in();
    for (int j = 0; j < 10; j++) tick();
    check("bp_drained", idle, 1'b1);

    // x0 sink
    do_reset();
    set_in(1, 0, 32'h55);
    tick();
    check("x0_ready", result_ready[1], 1'b1);
    check("x0_idle", idle, 1'b1);
    clear_in();
    for (int j = 0; j < 3; j++) begin
      tick();
      check("x0_nowrite", write_valid, 0);
      check("x0_idle_hold", idle, 1'b1);
    end

    // random traffic
    for (int j = 0; j < 1500; j++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < N; c++) begin
        result_valid[c] = ($urandom_range(0, 2) != 0);
        result[c].dest  = REG_ADDR_W'($urandom_range(0, 6));
        result[c].data  = $urandom;
      end
      tick();
    end
    reset = 1'b0;
    clear_in();
    for (int j = 0; j < 10; j++) tick();
    check("final_idle", idle, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_back_arb.md
# write_back_arb

Multi-channel writeback arbiter between the execution units and the register file. It accepts `RESULT` packets from N producer channels over valid/ready handshakes and buffers each channel in its own FIFO of depth DEPTH. Each cycle it drains up to W packets onto W registered register-file write ports, using round-robin arbitration with same-destination collision avoidance. It is the parametrised successor of the single-port `write_back` block and sits between the functional-unit result buses and the physical register file.

## Interface
- `N`, 4: number of producer channels (≥1).
- `W`, 2: number of register-file write ports (1 ≤ W ≤ N).
- `DEPTH`, 2: entries per channel FIFO (power of two, ≥2).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `result` in N×`RESULT`: per-channel packet (`dest` 7 b, `data` 32 b).
- `result_valid` in N: per-channel packet valid.
- `result_ready` out N: per-channel space available.
- `write_valid` out W: write port p carries a write this cycle.
- `write_addr` out W×7: destination register; 0 when port is invalid.
- `write_data` out W×32: write data; 0 when port is invalid.
- `idle` out 1: all FIFOs empty and no write valid.

## Operation
- Handshake: a packet is accepted on channel i when `result_valid[i] & result_ready[i]` at a rising edge with `reset` low.
- `result_ready[i]` is combinational and equals `count[i] != DEPTH`. It does not depend on `result_valid` or on same-cycle dequeue, so there is no ready→valid loop.
- Accepted packets with `dest == 0` are consumed and discarded (x0 sink). They are never enqueued and never written.
- Per channel, order is strictly FIFO. No ordering is enforced across channels.
- Arbitration each cycle, combinational over the FIFO heads:
  - scan channels starting at `rr`, upward, modulo N;
  - grant a non-empty channel if fewer than W grants exist so far and its head `dest` differs from every dest already granted this cycle;
  - a skipped channel stays eligible next cycle;
  - grant k is assigned to port k in scan order.
- Granted heads are popped at the edge, and the port outputs are registered from the granted heads.
- Round-robin update: if any grant occurs, `rr <= (last granted channel + 1) mod N`; otherwise `rr` holds.
- Simultaneous push and pop on a full FIFO: the pop frees a slot only for the next cycle, because ready was already low. `count` is unchanged on a simultaneous push and pop of a non-full FIFO.
- FIFO pointers are clog2(DEPTH) bits and wrap naturally; `count` is clog2(DEPTH)+1 bits.
- Reset, including mid-operation, does all of the following and accepts no packets in the reset cycle:
  - empties all FIFOs;
  - sets `rr = 0`;
  - zeroes `write_valid`, `write_addr` and `write_data`;
  - sets `result_ready = '1` and `idle = 1` from the next cycle;
  - drops in-flight packets silently.

## Timing
- Latency from a packet accepted at edge t to that packet on a write port:
  - minimum is 2 edges (grant in cycle t+1, outputs valid in cycle t+2, after edge t+1);
  - it is longer under contention.
- Each write port asserts valid for exactly one cycle per packet. Back-to-back writes on a port are allowed every cycle.
- Sustained throughput is min(W, active channels) packets per cycle when dests are distinct.
- With one channel backlogged and all others idle, that channel drains at 1 packet per cycle, because a channel receives at most one grant per cycle.
- `idle` is registered, computed from next-state counts and next `write_valid`.
- Port outputs are registered with no combinational path from `result*` to `write_*`.

## Structure
- Shared package:
  - `RESULT` typedef (`dest[6:0]`, `data[31:0]`);
  - `REG_ADDR_W = 7` and `REG_DATA_W = 32` constants.
- Sub-module `result_fifo #(DEPTH)`:
  - ports: synchronous-reset FIFO of `RESULT` with `push`, `pop`, `head`, `empty`, `full`, `count`;
  - instantiated N times.
- Top level holds the arbiter loop, the `rr` register and the output registers.

## Test plan
- **Reset mid-burst.** Load 3 packets, assert `reset` for 1 cycle, then release.
  - `write_valid = 0` from the cycle after the reset edge.
  - `result_ready = 4'b1111`, `idle = 1`.
  - None of the 3 packets is ever written.
- **Single packet latency.** Push ch2 {dest 5, data 0xDEADBEEF} at edge t.
  - `write_valid[0] = 1`, `write_addr[0] = 5`, `write_data[0] = 0xDEADBEEF` in cycle t+2 only.
  - Port 1 stays idle.
- **All four channels push in one cycle** (dests 1, 2, 3, 4, `rr = 0`).
  - Next-next cycle: ports carry dest 1 and 2.
  - Following cycle: dest 3 and 4.
  - `rr` ends at 0.
- **Dest collision.** Ch0 and ch1 both push dest 9, ch2 pushes dest 10.
  - First write cycle: ports carry dest 9 (ch0) and 10 (ch2).
  - Next cycle: ch1's dest 9 alone.
- **Back-pressure.** Ch3 pushes continuously with the write ports stalled by higher-priority traffic.
  - `result_ready[3]` drops after 2 accepts.
  - It re-asserts the cycle after ch3's first pop.
  - No packet is lost or reordered.
- **x0 sink.** Push dest 0 on ch1.
  - The packet is accepted.
  - No write ever appears and `idle` stays 1.
